// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: registered multicycle RV32I control unit with a memory request/ready handshake
module multicycle_ctrl_fsm #(
    parameter bit EN_JALR       = 1'b1,
    parameter bit EN_UTYPE      = 1'b1,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] immsrc,
    output logic [1:0] alu_op,
    output logic       illegal,
    output logic [3:0] state_dbg
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_EXECU    = 4'd12;

    logic [3:0] state, nxt, dispatch;
    logic       done;

    assign done = mem_ready | ~MEM_HANDSHAKE;

    // Unsupported opcodes dispatch back to FETCH; that doubles as the illegal flag
    assign dispatch = (op == 7'h03 || op == 7'h23)                   ? S_MEMADR :
                      (op == 7'h33)                                  ? S_EXECR  :
                      (op == 7'h13)                                  ? S_EXECI  :
                      (op == 7'h63)                                  ? S_BEQ    :
                      (op == 7'h6F)                                  ? S_JAL    :
                      (EN_JALR && op == 7'h67)                       ? S_JALR   :
                      (EN_UTYPE && (op == 7'h37 || op == 7'h17))     ? S_EXECU  : S_FETCH;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= S_FETCH;
        else       state <= nxt;

    always_comb begin
        nxt = S_FETCH;
        case (state)
            S_FETCH:                   nxt = done ? S_DECODE : S_FETCH;
            S_DECODE:                  nxt = dispatch;
            S_MEMADR:                  nxt = (op == 7'h03) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:                 nxt = done ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE:                nxt = done ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_EXECU,
            S_JAL:                     nxt = S_ALUWB;
            S_JALR:                    nxt = S_JAL;
            default:                   nxt = S_FETCH;
        endcase
    end

    // Outputs are forced low while reset is held so no enable fires in the reset cycle
    always_comb begin
        mem_req   = 1'b0;
        pcwrite   = 1'b0;
        adrsrc    = 1'b0;
        irwrite   = 1'b0;
        memwrite  = 1'b0;
        regwrite  = 1'b0;
        resultsrc = 2'b00;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        immsrc    = 3'b000;
        alu_op    = 2'b00;
        illegal   = 1'b0;
        state_dbg = 4'd0;
        if (!reset) begin
            state_dbg = state;
            immsrc = (op == 7'h23)                  ? 3'b001 :
                     (op == 7'h63)                  ? 3'b010 :
                     (op == 7'h6F)                  ? 3'b011 :
                     (op == 7'h37 || op == 7'h17)   ? 3'b100 : 3'b000;
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alusrcb   = 2'b10;
                    resultsrc = 2'b10;
                    irwrite   = done;
                    pcwrite   = done;
                end
                S_DECODE: begin
                    alusrca = 2'b01;
                    alusrcb = 2'b01;
                    illegal = (dispatch == S_FETCH);
                end
                S_MEMADR: begin
                    alusrca = 2'b10;
                    alusrcb = 2'b01;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adrsrc  = 1'b1;
                end
                S_MEMWB: begin
                    resultsrc = 2'b01;
                    regwrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req  = 1'b1;
                    adrsrc   = 1'b1;
                    memwrite = done;
                end
                S_EXECR: begin
                    alusrca = 2'b10;
                    alu_op  = 2'b10;
                end
                S_EXECI: begin
                    alusrca = 2'b10;
                    alusrcb = 2'b01;
                    alu_op  = 2'b10;
                end
                S_ALUWB: regwrite = 1'b1;
                S_BEQ: begin
                    alusrca = 2'b10;
                    alu_op  = 2'b01;
                    pcwrite = zero;
                end
                S_JAL: begin
                    alusrca = 2'b01;
                    alusrcb = 2'b10;
                    pcwrite = 1'b1;
                end
                S_JALR: begin
                    alusrca = 2'b10;
                    alusrcb = 2'b01;
                end
                S_EXECU: begin
                    alusrca = op[5] ? 2'b11 : 2'b01;
                    alusrcb = 2'b01;
                end
                default: illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: randomized instruction-level checks of the multicycle control FSM
module tb_multicycle_ctrl_fsm;
    logic clk, reset;
    logic [6:0] op_a, op_b;
    logic zero_a, zero_b, rdy_a, rdy_b;
    logic mem_req_a, pcwrite_a, adrsrc_a, irwrite_a, memwrite_a, regwrite_a, illegal_a;
    logic mem_req_b, pcwrite_b, adrsrc_b, irwrite_b, memwrite_b, regwrite_b, illegal_b;
    logic [1:0] resultsrc_a, alusrca_a, alusrcb_a, alu_op_a;
    logic [1:0] resultsrc_b, alusrca_b, alusrcb_b, alu_op_b;
    logic [2:0] immsrc_a, immsrc_b;
    logic [3:0] state_a, state_b;
    logic [21:0] obs_a, obs_b;
    int checks = 0;
    int errors = 0;

    multicycle_ctrl_fsm dut_a (
        .clk(clk), .reset(reset), .op(op_a), .zero(zero_a), .mem_ready(rdy_a),
        .mem_req(mem_req_a), .pcwrite(pcwrite_a), .adrsrc(adrsrc_a), .irwrite(irwrite_a),
        .memwrite(memwrite_a), .regwrite(regwrite_a), .resultsrc(resultsrc_a), .alusrca(alusrca_a),
        .alusrcb(alusrcb_a), .immsrc(immsrc_a), .alu_op(alu_op_a), .illegal(illegal_a), .state_dbg(state_a)
    );

    multicycle_ctrl_fsm #(.EN_JALR(1'b0), .EN_UTYPE(1'b0), .MEM_HANDSHAKE(1'b1)) dut_b (
        .clk(clk), .reset(reset), .op(op_b), .zero(zero_b), .mem_ready(rdy_b),
        .mem_req(mem_req_b), .pcwrite(pcwrite_b), .adrsrc(adrsrc_b), .irwrite(irwrite_b),
        .memwrite(memwrite_b), .regwrite(regwrite_b), .resultsrc(resultsrc_b), .alusrca(alusrca_b),
        .alusrcb(alusrcb_b), .immsrc(immsrc_b), .alu_op(alu_op_b), .illegal(illegal_b), .state_dbg(state_b)
    );

    assign obs_a = {mem_req_a, pcwrite_a, adrsrc_a, irwrite_a, memwrite_a, regwrite_a,
                    resultsrc_a, alusrca_a, alusrcb_a, immsrc_a, alu_op_a, illegal_a, state_a};
    assign obs_b = {mem_req_b, pcwrite_b, adrsrc_b, irwrite_b, memwrite_b, regwrite_b,
                    resultsrc_b, alusrca_b, alusrcb_b, immsrc_b, alu_op_b, illegal_b, state_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] imm_of(input logic [6:0] o);
        case (o)
            7'h23:        return 3'b001;
            7'h63:        return 3'b010;
            7'h6F:        return 3'b011;
            7'h37, 7'h17: return 3'b100;
            default:      return 3'b000;
        endcase
    endfunction

    // Expected control word for one cycle spent in phase p
    function automatic logic [21:0] exp_vec(input int p, input logic [6:0] o, input logic z,
                                            input logic rdy, input logic ill);
        logic mreq, pcw, adr, irw, mw, rw, il;
        logic [1:0] rs, sa, sb, ao;
        {mreq, pcw, adr, irw, mw, rw, il} = '0;
        {rs, sa, sb, ao} = '0;
        case (p)
            0:  begin mreq = 1; sb = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            1:  begin sa = 2'b01; sb = 2'b01; il = ill; end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  begin mreq = 1; adr = 1; end
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin mreq = 1; adr = 1; mw = rdy; end
            6:  begin sa = 2'b10; ao = 2'b10; end
            7:  begin sa = 2'b10; sb = 2'b01; ao = 2'b10; end
            8:  rw = 1;
            9:  begin sa = 2'b10; ao = 2'b01; pcw = z; end
            10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            11: begin sa = 2'b10; sb = 2'b01; end
            12: begin sa = (o == 7'h37) ? 2'b11 : 2'b01; sb = 2'b01; end
            default: il = 1;
        endcase
        return {mreq, pcw, adr, irw, mw, rw, rs, sa, sb, imm_of(o), ao, il, 4'(p)};
    endfunction

    // Runs one instruction from FETCH; fw/mw = ready-low cycles in FETCH / memory access
    task automatic run_instr(input bit b, input logic [6:0] o, input logic z, input int fw,
                             input int mw, input int rst_at, input string nm);
        int path[$];
        bit en;
        logic ill, r;
        logic [21:0] e, g;
        en = !b;
        case (o)
            7'h03:        path = '{0, 1, 2, 3, 4};
            7'h23:        path = '{0, 1, 2, 5};
            7'h33:        path = '{0, 1, 6, 8};
            7'h13:        path = '{0, 1, 7, 8};
            7'h63:        path = '{0, 1, 9};
            7'h6F:        path = '{0, 1, 10, 8};
            7'h67:        if (en) path = '{0, 1, 11, 10, 8}; else path = '{0, 1};
            7'h37, 7'h17: if (en) path = '{0, 1, 12, 8}; else path = '{0, 1};
            default:      path = '{0, 1};
        endcase
        ill = (path.size() == 2);
        foreach (path[i]) begin
            int n;
            n = (path[i] == 0) ? fw : (path[i] == 3 || path[i] == 5) ? mw : 0;
            for (int k = 0; k <= n; k++) begin
                r = (path[i] == 0 || path[i] == 3 || path[i] == 5) ? (k == n) : 1'($urandom);
                if (b) begin op_b = o; zero_b = z; rdy_b = r; rdy_a = 0; end
                else   begin op_a = o; zero_a = z; rdy_a = r; rdy_b = 0; end
                @(negedge clk);
                e = exp_vec(path[i], o, z, r, ill);
                g = b ? obs_b : obs_a;
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL %s op=%h step %0d wait %0d got=%h exp=%h", nm, o, i, k, g, e);
                end
                if (i == rst_at) begin
                    reset = 1;
                    #1;
                    g = b ? obs_b : obs_a;
                    checks++;
                    if (g !== 22'd0) begin errors++; $display("FAIL %s_reset_now got=%h exp=0", nm, g); end
                    @(posedge clk);
                    #1;
                    g = b ? obs_b : obs_a;
                    checks++;
                    if (g !== 22'd0) begin errors++; $display("FAIL %s_reset_hold got=%h exp=0", nm, g); end
                    rdy_a = 0;
                    rdy_b = 0;
                    @(negedge clk);
                    reset = 0;
                    @(posedge clk);
                    #1;
                    return;
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 0; op_a = 7'h33; op_b = 7'h33;
        zero_a = 0; zero_b = 0; rdy_a = 1; rdy_b = 1;
        #1 reset = 1;
        #2;
        checks++;
        if (obs_a !== 22'd0) begin errors++; $display("FAIL reset_a got=%h exp=0", obs_a); end
        checks++;
        if (obs_b !== 22'd0) begin errors++; $display("FAIL reset_b got=%h exp=0", obs_b); end
        @(posedge clk);
        @(negedge clk);
        rdy_a = 0; rdy_b = 0;
        reset = 0;
        #1;
        checks++;
        if (obs_a !== exp_vec(0, 7'h33, 0, 0, 0)) begin errors++; $display("FAIL reset_release got=%h", obs_a); end
        @(posedge clk);
        @(negedge clk);
        rdy_a = 1;
        reset = 1;
        #1;
        checks++;
        if (obs_a !== 22'd0) begin errors++; $display("FAIL reset_async got=%h exp=0", obs_a); end
        @(posedge clk);
        @(negedge clk);
        rdy_a = 0;
        reset = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rtype();   run_instr(0, 7'h33, 0, 0, 0, -1, "rtype"); endtask
    task automatic test_load();    run_instr(0, 7'h03, 0, 3, 2, -1, "load_stall"); endtask
    task automatic test_store();   run_instr(0, 7'h23, 0, 0, 2, -1, "store_stall"); endtask

    task automatic test_beq();
        run_instr(0, 7'h63, 1, 0, 0, -1, "beq_taken");
        run_instr(0, 7'h63, 0, 1, 0, -1, "beq_not_taken");
    endtask

    task automatic test_jalr();
        run_instr(0, 7'h67, 0, 0, 0, -1, "jalr_en");
        run_instr(1, 7'h67, 0, 0, 0, -1, "jalr_dis");
        run_instr(0, 7'h7F, 0, 0, 0, -1, "illegal_op");
    endtask

    task automatic test_utype();
        run_instr(0, 7'h37, 0, 0, 0, -1, "lui");
        run_instr(0, 7'h17, 0, 0, 0, -1, "auipc");
        run_instr(1, 7'h37, 0, 0, 0, -1, "lui_dis");
        run_instr(0, 7'h37, 0, 0, 0, 2, "lui_reset");
        run_instr(0, 7'h03, 0, 0, 2, 3, "load_reset");
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [10];
        logic [6:0] o;
        ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
        for (int t = 0; t < 60; t++) begin
            o = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
            run_instr(1'($urandom), o, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load();
        test_store();
        test_beq();
        test_jalr();
        test_utype();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Control unit for the multicycle RV32I datapath, replacing per-opcode combinational decoding with a registered state machine.
- Sequences fetch, decode, execute, memory and writeback over several cycles and drives all datapath selects and enables.
- Adds a memory request/ready handshake, optional JALR and LUI/AUIPC support, and illegal-opcode reporting.

Parameters:
EN_JALR, 1, 1 = decode jalr (0x67); 0 = treat as illegal.
EN_UTYPE, 1, 1 = decode lui (0x37) and auipc (0x17); 0 = treat as illegal.
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored (single-cycle memory).

Ports:
clk  in  1  clock; all state changes on rising edge.
reset  in  1  asynchronous, active-high; forces state to FETCH.
op  in  7  opcode from instruction register; stable from DECODE onward.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completed access this cycle.
mem_req  out  1  memory access request.
pcwrite  out  1  PC register enable.
adrsrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
irwrite  out  1  instruction/OldPC register enable.
memwrite  out  1  data memory write enable.
regwrite  out  1  register file write enable.
resultsrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
alusrca  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
alusrcb  out  2  00 rs2, 01 ImmExt, 10 constant 4.
immsrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded.
illegal  out  1  one-cycle pulse on unsupported opcode.
state_dbg  out  4  current state encoding.

Behaviour:
- Reset: async assert sets state to FETCH (0). While reset is high, every output except state_dbg is 0 and state_dbg is 0. After reset release, the first clock edge is evaluated in FETCH.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, JALR 11, EXECU 12. Codes 13-15 go to FETCH on the next edge, with illegal=1 during that cycle.
- Per-state outputs (unlisted outputs are 0; alusrca/alusrcb/resultsrc are 00 where unlisted):
  - FETCH: mem_req=1, adrsrc=0, alusrcb=10, resultsrc=10. irwrite and pcwrite are 1 only when done = (mem_ready | ~MEM_HANDSHAKE).
  - DECODE: alusrca=01, alusrcb=01, alu_op=00 (branch/jal target into ALUOut).
  - MEMADR: alusrca=10, alusrcb=01.
  - MEMREAD: mem_req=1, adrsrc=1.
  - MEMWB: resultsrc=01, regwrite=1.
  - MEMWRITE: mem_req=1, adrsrc=1; memwrite = done.
  - EXECR: alusrca=10, alu_op=10.
  - EXECI: alusrca=10, alusrcb=01, alu_op=10.
  - ALUWB: regwrite=1.
  - BEQ: alusrca=10, alu_op=01; pcwrite = zero.
  - JAL: alusrca=01, alusrcb=10, pcwrite=1 (PC <= ALUOut, ALU computes OldPC+4).
  - JALR: alusrca=10, alusrcb=01.
  - EXECU: alusrca = 11 if op[5]=1 (lui) else 01 (auipc); alusrcb=01.
- immsrc is combinational from op in every state: 0x03/0x13/0x67 give I; 0x23 gives S; 0x63 gives B; 0x6F gives J; 0x37/0x17 give U; otherwise 000.
- Transitions:
  - FETCH goes to DECODE when done, else holds.
  - DECODE dispatches on op:
    - 0x03 or 0x23 go to MEMADR.
    - 0x33 goes to EXECR.
    - 0x13 goes to EXECI.
    - 0x63 goes to BEQ.
    - 0x6F goes to JAL.
    - 0x67 goes to JALR if EN_JALR.
    - 0x37/0x17 go to EXECU if EN_UTYPE.
    - Otherwise: illegal=1 for that cycle, then FETCH (instruction skipped; PC already advanced).
  - MEMADR goes to MEMREAD if op=0x03, else MEMWRITE.
  - MEMREAD goes to MEMWB when done, else holds.
  - MEMWRITE goes to FETCH when done, else holds.
  - MEMWB, BEQ go to FETCH.
  - EXECR, EXECI, EXECU go to ALUWB.
  - JALR goes to JAL.
  - JAL goes to ALUWB.
  - ALUWB goes to FETCH.
- Stall rule: while waiting for mem_ready, no enable (pcwrite, irwrite, memwrite, regwrite) is asserted more than once per access, and memwrite is asserted for exactly one cycle. mem_ready outside FETCH/MEMREAD/MEMWRITE is ignored.
- Reset during a stalled access abandons it; no enable fires in the reset cycle.

Test Plan:
1. Reset, MEM_HANDSHAKE=1, op=0x33, mem_ready=1 always -> states 0,1,6,8,0. pcwrite and irwrite high only in cycle 1; regwrite only in ALUWB; alu_op=10 in EXECR.
2. op=0x03 with mem_ready low for 3 cycles in FETCH and 2 in MEMREAD -> FETCH held 4 cycles with irwrite/pcwrite only on the last; MEMREAD held 3 cycles; MEMWB regwrite=1, resultsrc=01.
3. op=0x23 with mem_ready low 2 cycles in MEMWRITE -> memwrite high exactly once (the ready cycle), regwrite never asserted, returns to FETCH.
4. op=0x63: with zero=1 -> BEQ pcwrite=1, immsrc=010; with zero=0 -> pcwrite=0; each takes 3 states total.
5. op=0x67 with EN_JALR=1 -> states 0,1,11,10,8,0 (JAL pcwrite=1, ALUWB regwrite=1); with EN_JALR=0 -> illegal pulse in DECODE, then FETCH.
6. op=0x37 -> EXECU alusrca=11, immsrc=100; op=0x17 -> alusrca=01; reset asserted mid-EXECU -> all outputs 0 immediately, state_dbg=0.
